// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//   Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
//   handshakes on both sides. Operands are split into 4-bit lookahead groups:
//   stage 1 registers the bit generate/propagate/half-sum terms and the group
//   G/P; stage 2 runs a second-level lookahead across the groups, expands the
//   intra-group carries and registers the result flags.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      beat can be accepted this cycle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in, used only when in_sub = 0
//   in_sub     in   1      1: A - B, 0: A + B + cin
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   out_sum    out  WIDTH  result, modulo 2^WIDTH
//   out_cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf    out  1      signed two's-complement overflow
//   out_zero   out  1      out_sum == 0
//   out_gp     out  2      word-level {G, P}, independent of carry-in
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [1:0]       out_gp
);

  localparam int GW   = 32'sd4;
  localparam int NGRP = WIDTH / GW;

  if (((WIDTH % GW) != 32'sd0) || (WIDTH < 32'sd4) || (WIDTH > 32'sd64)) begin : g_width_check
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in the range 4..64");
  end

  // Group generate/propagate of one 4-bit group, returned as {G, P}.
  function automatic logic [1:0] grp_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  // Carry into each bit of a 4-bit group, given the group carry-in.
  function automatic logic [3:0] grp_carry(input logic [3:0] g, input logic [3:0] p,
                                           input logic c);
    logic [3:0] cv;
    cv[0] = c;
    cv[1] = g[0] | (p[0] & c);
    cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return cv;
  endfunction

  // Second-level lookahead: every group carry is a flat sum of products of the
  // group G/P terms and the carry-in, never a chain through the previous carry.
  function automatic logic [NGRP:0] lookahead(input logic [NGRP-1:0] gg,
                                              input logic [NGRP-1:0] pp,
                                              input logic c);
    logic [NGRP:0] cv;
    logic          acc;
    logic          prod;
    cv[0] = c;
    for (int k = 32'sd0; k < NGRP; k++) begin
      acc  = gg[k];
      prod = pp[k];
      for (int j = k - 32'sd1; j >= 32'sd0; j--) begin
        acc  = acc | (prod & gg[j]);
        prod = prod & pp[j];
      end
      cv[k+1] = acc | (prod & c);
    end
    return cv;
  endfunction

  // ---------------------------------------------------------------------------
  // Flow control: two register stages, no skid buffer.
  // ---------------------------------------------------------------------------
  logic s1_valid_r;
  logic s2_adv_s;
  logic s1_adv_s;
  logic in_xfer_s;

  // Stage advance terms; in_ready depends on out_ready but never on in_valid.
  always_comb begin
    s2_adv_s  = ~out_valid | out_ready;
    s1_adv_s  = ~s1_valid_r | s2_adv_s;
    in_ready  = s1_adv_s;
    in_xfer_s = in_valid & s1_adv_s;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: operand conditioning, bit g/p/x, group G/P.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] x_s;
  logic [NGRP-1:0]  grp_g_s;
  logic [NGRP-1:0]  grp_p_s;

  // Subtract is A + ~B + 1, so in_cin is replaced by 1 in that mode.
  always_comb begin
    b_eff_s = in_sub ? ~in_b : in_b;
    c0_s    = in_sub ? 1'b1 : in_cin;
    g_s     = in_a & b_eff_s;
    p_s     = in_a | b_eff_s;
    x_s     = in_a ^ b_eff_s;
    grp_g_s = '0;
    grp_p_s = '0;
    for (int k = 32'sd0; k < NGRP; k++) begin
      {grp_g_s[k], grp_p_s[k]} = grp_gp(g_s[k*GW +: GW], p_s[k*GW +: GW]);
    end
  end

  logic [WIDTH-1:0] s1_g_r;
  logic [WIDTH-1:0] s1_p_r;
  logic [WIDTH-1:0] s1_x_r;
  logic [NGRP-1:0]  s1_gg_r;
  logic [NGRP-1:0]  s1_gp_r;
  logic             s1_c0_r;
  logic             s1_amsb_r;
  logic             s1_bmsb_r;

  // Stage 1 register: valid follows the input whenever the stage may advance,
  // payload only loads on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_g_r     <= '0;
      s1_p_r     <= '0;
      s1_x_r     <= '0;
      s1_gg_r    <= '0;
      s1_gp_r    <= '0;
      s1_c0_r    <= 1'b0;
      s1_amsb_r  <= 1'b0;
      s1_bmsb_r  <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= in_valid;
      end
      if (in_xfer_s) begin
        s1_g_r    <= g_s;
        s1_p_r    <= p_s;
        s1_x_r    <= x_s;
        s1_gg_r   <= grp_g_s;
        s1_gp_r   <= grp_p_s;
        s1_c0_r   <= c0_s;
        s1_amsb_r <= in_a[WIDTH-1];
        s1_bmsb_r <= b_eff_s[WIDTH-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: group carries, bit carries, sum and flags.
  // ---------------------------------------------------------------------------
  logic [NGRP:0]    grp_c_s;
  logic [NGRP:0]    word_c_s;
  logic [WIDTH-1:0] bit_c_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             zero_s;
  logic [1:0]       gp_s;

  // Word G is the group lookahead evaluated with a zero carry-in.
  always_comb begin
    grp_c_s  = lookahead(s1_gg_r, s1_gp_r, s1_c0_r);
    word_c_s = lookahead(s1_gg_r, s1_gp_r, 1'b0);
    bit_c_s  = '0;
    for (int k = 32'sd0; k < NGRP; k++) begin
      bit_c_s[k*GW +: GW] = grp_carry(s1_g_r[k*GW +: GW], s1_p_r[k*GW +: GW], grp_c_s[k]);
    end
    sum_s  = s1_x_r ^ bit_c_s;
    cout_s = grp_c_s[NGRP];
    ovf_s  = (s1_amsb_r == s1_bmsb_r) & (sum_s[WIDTH-1] != s1_amsb_r);
    zero_s = ~|sum_s;
    gp_s   = {word_c_s[NGRP], &s1_gp_r};
  end

  // Output register: holds while the consumer stalls, loads when stage 1 moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_gp    <= 2'b00;
    end else begin
      if (s2_adv_s) begin
        out_valid <= s1_valid_r;
      end
      if (s2_adv_s & s1_valid_r) begin
        out_sum  <= sum_s;
        out_cout <= cout_s;
        out_ovf  <= ovf_s;
        out_zero <= zero_s;
        out_gp   <= gp_s;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_pipe
//   Runs three instances (WIDTH 4, 16, 64) side by side. Each instance goes
//   through directed corner cases, a backpressure sequence, a mid-flight reset
//   (the reset line is shared and driven by the top-level process) and a
//   randomised stream compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_cla_adder_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [1:0]  gp;
  } res_t;

  localparam int NB = 10000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain integer arithmetic on the conditioned operands.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0]        m, am, be;
    logic               c0;
    logic [64:0]        tot, gsum;
    logic signed [66:0] sa, sb, st, lim;
    res_t               r;
    m    = wmask(w);
    am   = a & m;
    be   = (sub ? ~b : b) & m;
    c0   = sub ? 1'b1 : cin;
    tot  = {1'b0, am} + {1'b0, be} + {64'd0, c0};
    gsum = {1'b0, am} + {1'b0, be};
    r.sum  = tot[63:0] & m;
    r.cout = tot[w];
    r.zero = (r.sum == 64'd0);
    r.gp   = {gsum[w], (((am | be) & m) == m)};
    sa = $signed({3'b000, am});
    if (am[w-1]) sa = sa - (67'sd1 <<< w);
    sb = $signed({3'b000, be});
    if (be[w-1]) sb = sb - (67'sd1 <<< w);
    st  = sa + sb + $signed({66'd0, c0});
    lim = 67'sd1 <<< (w - 1);
    r.ovf = (st >= lim) || (st < -lim);
    return r;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = wmask(w);
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 16 : 64);

    logic         iv = 1'b0, cin = 1'b0, sub = 1'b0, ordy = 1'b0;
    logic         ir, ov, cout, ovf, zero;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] sum;
    logic [1:0]   gp;
    logic         rst_ready = 1'b0;
    logic         done = 1'b0;
    string        pre;
    res_t         q[$];

    cla_adder_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b), .in_cin(cin), .in_sub(sub),
      .out_valid(ov), .out_ready(ordy), .out_sum(sum), .out_cout(cout),
      .out_ovf(ovf), .out_zero(zero), .out_gp(gp)
    );

    // One isolated beat: accepted at once, invisible after one edge, valid after two.
    task automatic one_beat(input string nm, input logic [63:0] ta, input logic [63:0] tb_v,
                            input logic tcin, input logic tsub, input logic [63:0] esum,
                            input logic ecout, input logic eovf, input logic ezero);
      @(negedge clk);
      a = ta[W-1:0]; b = tb_v[W-1:0]; cin = tcin; sub = tsub; iv = 1'b1; ordy = 1'b1;
      #1 chk({pre, " ", nm, " in_ready"}, 64'(ir), 64'd1);
      @(negedge clk);
      iv = 1'b0;
      #1 chk({pre, " ", nm, " early_valid"}, 64'(ov), 64'd0);
      @(negedge clk);
      #1;
      chk({pre, " ", nm, " valid"}, 64'(ov), 64'd1);
      chk({pre, " ", nm, " sum"}, 64'(sum), esum);
      chk({pre, " ", nm, " cout_ovf_zero"}, {61'd0, cout, ovf, zero}, {61'd0, ecout, eovf, ezero});
    endtask

    initial begin
      logic [63:0] m, msb;
      logic [63:0] ba[4], bb[4];
      res_t        bp[4];
      res_t        e;
      int          nacc, nout, first_c, last_c, issued, got;
      logic        took;
      pre = $sformatf("w%0d", W);
      m   = wmask(W);
      msb = 64'd1 << (W - 1);

      // reset state
      @(negedge clk);
      #1;
      chk({pre, " reset out_valid"}, 64'(ov), 64'd0);
      chk({pre, " reset outputs"}, {59'd0, cout, ovf, zero, gp} | 64'(sum), 64'd0);
      wait (!rst);
      @(negedge clk);
      #1 chk({pre, " after reset in_ready"}, 64'(ir), 64'd1);

      // directed corners
      one_beat("add_wrap", m, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      one_beat("ovf_pos", msb - 64'd1, 64'd1, 1'b0, 1'b0, msb, 1'b0, 1'b1, 1'b0);
      one_beat("ovf_neg", msb, m, 1'b0, 1'b0, msb - 64'd1, 1'b1, 1'b1, 1'b0);
      one_beat("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, m - 64'd1, 1'b0, 1'b0, 1'b0);
      one_beat("sub_noborrow", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);

      // backpressure: four beats offered against a stalled consumer
      for (int k = 0; k < 4; k++) begin
        ba[k] = pick(W);
        bb[k] = pick(W);
        bp[k] = model(W, ba[k], bb[k], 1'(k), 1'(k >> 1));
      end
      nacc = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (nacc < 4) begin
          a = ba[nacc][W-1:0]; b = bb[nacc][W-1:0]; cin = 1'(nacc); sub = 1'(nacc >> 1);
        end
        iv = 1'b1; ordy = 1'b0;
        #1;
        if (c >= 2) begin
          chk({pre, " bp in_ready"}, 64'(ir), 64'd0);
          chk({pre, " bp held valid"}, 64'(ov), 64'd1);
          chk({pre, " bp held sum"}, 64'(sum), bp[0].sum);
        end
        if (iv && ir) nacc++;
      end
      chk({pre, " bp accepted"}, 64'(nacc), 64'd2);
      nout = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 12 && nout < 4; c++) begin
        @(negedge clk);
        if (nacc < 4) begin
          a = ba[nacc][W-1:0]; b = bb[nacc][W-1:0]; cin = 1'(nacc); sub = 1'(nacc >> 1);
          iv = 1'b1;
        end else begin
          iv = 1'b0;
        end
        ordy = 1'b1;
        #1;
        if (ov) begin
          chk({pre, " bp drain sum"}, 64'(sum), bp[nout].sum);
          chk({pre, " bp drain flags"}, {59'd0, cout, ovf, zero, gp},
              {59'd0, bp[nout].cout, bp[nout].ovf, bp[nout].zero, bp[nout].gp});
          if (first_c < 0) first_c = c;
          last_c = c;
          nout++;
        end
        if (iv && ir) nacc++;
      end
      chk({pre, " bp drained"}, 64'(nout), 64'd4);
      chk({pre, " bp one per cycle"}, 64'(last_c - first_c), 64'd3);

      // fill both stages, then hand over to the shared reset
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        a = pick(W); b = pick(W); cin = 1'b0; sub = 1'b0; iv = 1'b1; ordy = 1'b0;
      end
      @(negedge clk);
      iv = 1'b0;
      #1;
      chk({pre, " full valid"}, 64'(ov), 64'd1);
      chk({pre, " full in_ready"}, 64'(ir), 64'd0);
      rst_ready = 1'b1;
      wait (rst);
      #1 chk({pre, " async reset drops valid"}, 64'(ov), 64'd0);
      wait (!rst);
      @(negedge clk);
      ordy = 1'b1;
      #1;
      chk({pre, " post reset in_ready"}, 64'(ir), 64'd1);
      chk({pre, " post reset valid"}, 64'(ov), 64'd0);
      nout = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #1 if (ov) nout++;
      end
      chk({pre, " no stale beat"}, 64'(nout), 64'd0);

      // randomised stream against the model
      took = 1'b0; issued = 0; got = 0;
      for (int c = 0; c < 60000 && got < NB; c++) begin
        @(negedge clk);
        if (!iv || took) begin
          if (issued < NB && $urandom_range(3) != 0) begin
            a = pick(W); b = pick(W);
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            iv = 1'b1;
          end else begin
            iv = 1'b0;
          end
        end
        ordy = ($urandom_range(3) != 0);
        #1;
        if (ov && ordy) begin
          if (q.size() == 0) begin
            chk({pre, " rand unexpected beat"}, 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk({pre, " rand sum"}, 64'(sum), e.sum);
            chk({pre, " rand flags"}, {59'd0, cout, ovf, zero, gp},
                {59'd0, e.cout, e.ovf, e.zero, e.gp});
          end
          got++;
        end
        took = iv && ir;
        if (took) begin
          q.push_back(model(W, 64'(a), 64'(b), cin, sub));
          issued++;
        end
      end
      chk({pre, " rand beats out"}, 64'(got), 64'(NB));
      chk({pre, " rand leftover"}, 64'(q.size()), 64'd0);
      iv = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    n = 0;
    while (!(g_w[0].rst_ready && g_w[1].rst_ready && g_w[2].rst_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reset rendezvous", 64'(n < 2000), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    n = 0;
    while (!(g_w[0].done && g_w[1].done && g_w[2].done) && n < 80000) begin
      @(negedge clk);
      n++;
    end
    chk("stream completion", 64'(n < 80000), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
